// File: rtl/mult_stream_ctrl_pkg.sv
// Shared configuration for the multiplier stream controller: default widths,
// multiplier latency and the result-buffer sizing rule.
package mult_stream_ctrl_pkg;

  localparam int unsigned OP_W_DEF    = 16;
  localparam int unsigned TAG_W_DEF   = 4;
  localparam int unsigned MUL_LAT_CFG = 4;
  localparam int unsigned DEPTH_DEF   = 8;

  // The buffer must be able to absorb every operation the pipeline can hold.
  function automatic bit depth_ok(input int unsigned depth, input int unsigned mul_lat);
    return depth >= mul_lat + 1;
  endfunction

endpackage

// File: rtl/mult_result_fifo.sv
// Result buffer: synchronous FIFO with a registered head entry, valid flag and count.
module mult_result_fifo #(
  parameter int unsigned W     = 36,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 wdata,
  input  logic                         pop,
  output logic                         out_valid,
  output logic [W-1:0]                 rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic [W-1:0]     rdata_q, rdata_d;
  logic             pop_c;
  logic             full_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Head register is reloaded from the new read pointer, or straight from
  // wdata when the entry being written is the one that becomes the head.
  always_comb begin
    pop_c    = pop & valid_q;
    full_c   = (count_q == CNT_W'(DEPTH));
    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q] = wdata;
    wr_ptr_d = push  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_c ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop_c);
    valid_d  = (count_d != '0);
    rdata_d  = rdata_q;
    if (push && (wr_ptr_q == rd_ptr_d)) rdata_d = wdata;
    else if (valid_d)                    rdata_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Upstream credit accounting makes a push into a full buffer impossible.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(push && full_c && !pop_c)) else $error("mult_result_fifo: push while full");
    end
  end

  assign out_valid = valid_q;
  assign rdata     = rdata_q;
  assign count     = count_q;

endmodule

// File: rtl/mult_stream_ctrl.sv
// Streams operand pairs into an external pipelined multiplier and buffers the
// tagged products, using occupancy-based flow control so results never overflow.
module mult_stream_ctrl
  import mult_stream_ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = OP_W_DEF,
  parameter int unsigned TAG_W   = TAG_W_DEF,
  parameter int unsigned MUL_LAT = MUL_LAT_CFG,
  parameter int unsigned DEPTH   = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic [2*OP_W-1:0] mul_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*OP_W-1:0] out_p,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);
  localparam int unsigned PROD_W = 2 * OP_W;
  localparam int unsigned ENT_W  = PROD_W + TAG_W;
  localparam int unsigned PIPE_N = MUL_LAT + 1;
  localparam int unsigned OCC_W  = $clog2(DEPTH + 1);

  if (!depth_ok(DEPTH, MUL_LAT)) begin : g_depth_chk
    $error("mult_stream_ctrl: DEPTH must be at least MUL_LAT+1");
  end

  logic [PIPE_N-1:0]            vld_q, vld_d;
  logic [PIPE_N-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [OP_W-1:0]              mul_a_q, mul_a_d;
  logic [OP_W-1:0]              mul_b_q, mul_b_d;
  logic [OCC_W-1:0]             occ_q, occ_d;
  logic                         in_ready_q, in_ready_d;
  logic                         busy_q, busy_d;
  logic                         accept_c, pop_c, push_c;
  logic [ENT_W-1:0]             push_data_c;
  logic [ENT_W-1:0]             fifo_rdata;
  logic [OCC_W-1:0]             fifo_count;
  logic [OCC_W-1:0]             inflight_c;

  // Occupancy counts a slot from accept until pop, so in_ready is pure credit.
  always_comb begin
    accept_c    = in_valid & in_ready_q;
    pop_c       = out_valid & out_ready;
    push_c      = vld_q[PIPE_N-1];
    push_data_c = {mul_p, tag_q[PIPE_N-1]};
    vld_d       = {vld_q[PIPE_N-2:0], accept_c};
    tag_d       = {tag_q[PIPE_N-2:0], in_tag};
    mul_a_d     = accept_c ? in_a : '0;
    mul_b_d     = accept_c ? in_b : '0;
    occ_d       = occ_q + OCC_W'(accept_c) - OCC_W'(pop_c);
    in_ready_d  = (occ_d < OCC_W'(DEPTH));
    busy_d      = (occ_d != '0);
  end

  always_comb begin
    inflight_c = '0;
    for (int unsigned i = 0; i < PIPE_N; i++) inflight_c += OCC_W'(vld_q[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q      <= '0;
      tag_q      <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      occ_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      tag_q      <= tag_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      occ_q      <= occ_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (occ_q == fifo_count + inflight_c) else $error("mult_stream_ctrl: occupancy drift");
    end
  end

  mult_result_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .wdata     (push_data_c),
    .pop       (pop_c),
    .out_valid (out_valid),
    .rdata     (fifo_rdata),
    .count     (fifo_count)
  );

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;
  assign out_p    = fifo_rdata[ENT_W-1:TAG_W];
  assign out_tag  = fifo_rdata[TAG_W-1:0];

endmodule

// File: tb/tb_mult_stream_ctrl.sv
// Self-checking bench for mult_stream_ctrl with a 4-stage registered multiplier model.
module tb_mult_stream_ctrl;
  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned DEPTH   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_a = '0, in_b = '0;
  logic [3:0]  in_tag = '0;
  logic        in_ready, out_valid, busy;
  logic [15:0] mul_a, mul_b;
  logic [31:0] mul_p, out_p;
  logic [3:0]  out_tag;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;

  typedef struct { logic [31:0] p; logic [3:0] t; } exp_t;
  exp_t exp_q[$];

  mult_stream_ctrl #(.OP_W(16), .TAG_W(4), .MUL_LAT(MUL_LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  // External multiplier: product of the registered operands, MUL_LAT edges later.
  logic [31:0] mp [MUL_LAT];
  always @(posedge clk) begin
    mp[0] <= {16'h0, mul_a} * {16'h0, mul_b};
    for (int i = 1; i < MUL_LAT; i++) mp[i] <= mp[i-1];
  end
  assign mul_p = mp[MUL_LAT-1];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  // Advance one clock; report the handshakes seen before the edge and the popped data.
  task automatic step(output bit acc, output bit popd, output logic [31:0] op, output logic [3:0] ot);
    acc  = rst && in_valid && in_ready;
    popd = rst && out_valid && out_ready;
    op   = out_p;
    ot   = out_tag;
    if (acc) exp_q.push_back('{p: {16'h0, in_a} * {16'h0, in_b}, t: in_tag});
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic randomize_inputs();
    in_a   = 16'($urandom);
    in_b   = 16'($urandom);
    in_tag = 4'($urandom);
  endtask

  task automatic test_reset();
    bit acc, popd; logic [31:0] op; logic [3:0] ot;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) step(acc, popd, op, ot);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (mul_a !== 16'h0 || mul_b !== 16'h0) begin errors++; $display("FAIL reset_mul_ops got=%h/%h want=0/0", mul_a, mul_b); end
    rst = 1'b1;
    step(acc, popd, op, ot);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_busy got=%b want=0", busy); end
  endtask

  task automatic test_basic();
    bit acc, popd; logic [31:0] op; logic [3:0] ot;
    exp_q.delete();
    out_ready = 1'b1; in_a = 16'd3; in_b = 16'd5; in_tag = 4'd1; in_valid = 1'b1;
    step(acc, popd, op, ot);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL basic_accept got=%b want=1", acc); end
    checks++; if (mul_a !== 16'd3 || mul_b !== 16'd5) begin errors++; $display("FAIL basic_mul_ops got=%h/%h want=3/5", mul_a, mul_b); end
    in_valid = 1'b0; in_a = '0; in_b = '0;
    for (int k = 1; k <= 8; k++) begin
      step(acc, popd, op, ot);
      if (k == 1) begin
        checks++; if (mul_a !== 16'h0) begin errors++; $display("FAIL basic_mul_idle got=%h want=0", mul_a); end
      end
      checks++;
      if (out_valid !== (k == 5)) begin errors++; $display("FAIL basic_latency edge=%0d out_valid got=%b want=%b", k, out_valid, (k == 5)); end
      if (k == 5) begin
        checks++;
        if (out_p !== 32'd15 || out_tag !== 4'd1) begin errors++; $display("FAIL basic_result got=%0d/%0d want=15/1", out_p, out_tag); end
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got=%b want=0", busy); end
    exp_q.delete();
  endtask

  task automatic test_corners();
    bit acc, popd; logic [31:0] op; logic [3:0] ot;
    logic [31:0] want_p [2];
    logic [3:0]  want_t [2];
    int n = 0;
    want_p[0] = 32'hFFFE0001; want_t[0] = 4'd2;
    want_p[1] = 32'h0;        want_t[1] = 4'd3;
    out_ready = 1'b1; in_valid = 1'b1;
    in_a = 16'hFFFF; in_b = 16'hFFFF; in_tag = 4'd2;
    step(acc, popd, op, ot);
    in_a = 16'h0; in_b = 16'h1234; in_tag = 4'd3;
    step(acc, popd, op, ot);
    in_valid = 1'b0;
    for (int j = 0; j < 20 && n < 2; j++) begin
      step(acc, popd, op, ot);
      if (popd) begin
        checks++;
        if (op !== want_p[n] || ot !== want_t[n]) begin
          errors++; $display("FAIL corner_result idx=%0d got=%h/%0d want=%h/%0d", n, op, ot, want_p[n], want_t[n]);
        end
        n++;
      end
    end
    checks++; if (n != 2) begin errors++; $display("FAIL corner_count got=%0d want=2", n); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    bit acc, popd; logic [31:0] op; logic [3:0] ot;
    exp_t e;
    int n = 0, drops = 0;
    int unsigned first_cyc = 0, last_cyc = 0;
    exp_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 20 + 30 && n < 20; i++) begin
      in_valid = (i < 20);
      if (i < 20) randomize_inputs();
      step(acc, popd, op, ot);
      if (i < 20 && !acc) drops++;
      if (popd) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_extra_pop got=%h want=none", op); end
        else begin
          e = exp_q.pop_front();
          if (op !== e.p || ot !== e.t) begin errors++; $display("FAIL b2b_result idx=%0d got=%h/%0d want=%h/%0d", n, op, ot, e.p, e.t); end
        end
        if (n == 0) first_cyc = cyc;
        last_cyc = cyc;
        n++;
      end
    end
    in_valid = 1'b0;
    checks++; if (drops != 0) begin errors++; $display("FAIL b2b_in_ready_drops got=%0d want=0", drops); end
    checks++; if (n != 20) begin errors++; $display("FAIL b2b_count got=%0d want=20", n); end
    checks++; if (last_cyc - first_cyc != 19) begin errors++; $display("FAIL b2b_throughput span got=%0d want=19", last_cyc - first_cyc); end
  endtask

  task automatic test_backpressure();
    bit acc, popd; logic [31:0] op; logic [3:0] ot;
    logic [31:0] held_p; logic [3:0] held_t;
    exp_t e;
    int nacc = 0, n = 0;
    exp_q.delete();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      randomize_inputs();
      step(acc, popd, op, ot);
      if (acc) nacc++;
    end
    in_valid = 1'b0;
    checks++; if (nacc != 8) begin errors++; $display("FAIL bp_accepted got=%0d want=8", nacc); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full got=%b want=0", in_ready); end
    checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL bp_valid_busy got=%b/%b want=1/1", out_valid, busy); end
    held_p = out_p; held_t = out_tag;
    repeat (2) step(acc, popd, op, ot);
    checks++; if (out_p !== held_p || out_tag !== held_t) begin errors++; $display("FAIL bp_hold got=%h/%0d want=%h/%0d", out_p, out_tag, held_p, held_t); end
    out_ready = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_before_pop got=%b want=0", in_ready); end
    for (int j = 0; j < 30 && exp_q.size() > 0; j++) begin
      step(acc, popd, op, ot);
      if (j == 0) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_after_pop got=%b want=1", in_ready); end
      end
      if (popd) begin
        checks++;
        e = exp_q.pop_front();
        if (op !== e.p || ot !== e.t) begin errors++; $display("FAIL bp_result idx=%0d got=%h/%0d want=%h/%0d", n, op, ot, e.p, e.t); end
        n++;
      end
    end
    checks++; if (n != 8) begin errors++; $display("FAIL bp_count got=%0d want=8", n); end
  endtask

  task automatic test_mid_reset();
    bit acc, popd; logic [31:0] op; logic [3:0] ot;
    int nacc = 0;
    bit seen = 1'b0;
    exp_q.delete();
    out_ready = 1'b1; in_valid = 1'b1;
    repeat (3) begin
      randomize_inputs();
      step(acc, popd, op, ot);
      if (acc) nacc++;
    end
    in_valid = 1'b0;
    checks++; if (nacc != 3) begin errors++; $display("FAIL mrst_accepted got=%0d want=3", nacc); end
    step(acc, popd, op, ot);
    rst = 1'b0;
    step(acc, popd, op, ot);
    checks++; if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL mrst_in_reset rdy/busy/vld got=%b/%b/%b want=0/0/0", in_ready, busy, out_valid);
    end
    rst = 1'b1;
    step(acc, popd, op, ot);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mrst_release_ready got=%b want=1", in_ready); end
    repeat (12) begin
      if (out_valid) seen = 1'b1;
      step(acc, popd, op, ot);
    end
    checks++; if (seen) begin errors++; $display("FAIL mrst_ghost_result got out_valid=1 want=0"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got=%b want=0", busy); end
    exp_q.delete();
  endtask

  task automatic test_full_stream();
    bit acc, popd; logic [31:0] op; logic [3:0] ot;
    exp_t e;
    int nacc = 0, n = 0;
    exp_q.delete();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      randomize_inputs();
      step(acc, popd, op, ot);
      if (acc) nacc++;
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 40 + 30 && (i < 40 || exp_q.size() > 0); i++) begin
      in_valid = (i < 40);
      if (i < 40) randomize_inputs();
      step(acc, popd, op, ot);
      if (acc) nacc++;
      if (popd) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL full_extra_pop got=%h want=none", op); end
        else begin
          e = exp_q.pop_front();
          if (op !== e.p || ot !== e.t) begin errors++; $display("FAIL full_result idx=%0d got=%h/%0d want=%h/%0d", n, op, ot, e.p, e.t); end
        end
        n++;
      end
    end
    in_valid = 1'b0;
    checks++; if (n != nacc || exp_q.size() != 0) begin errors++; $display("FAIL full_conservation pops=%0d want=%0d left=%0d", n, nacc, exp_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_after got=%b want=0", busy); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    test_full_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_stream_ctrl.md
MULT_STREAM_CTRL -- requirements
Module: mult_stream_ctrl

Interface
REQ-001 SHALL have parameter OP_W, default 16, operand width.
REQ-002 SHALL have parameter TAG_W, default 4, width of the user tag carried with each operation.
REQ-003 SHALL have parameter MUL_LAT, default 4, clock edges from operands on mul_a/mul_b to the valid product on mul_p.
REQ-004 SHALL have parameter DEPTH, default 8, result FIFO entries; must be at least MUL_LAT+1.
REQ-005 SHALL have port clk  in  1  single clock; all logic on the rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port in_valid  in  1  operand pair offered.
REQ-008 SHALL have port in_ready  out  1  operand pair can be accepted.
REQ-009 SHALL have ports in_a and in_b  in  OP_W each  operands.
REQ-010 SHALL have port in_tag  in  TAG_W  user tag.
REQ-011 SHALL have ports mul_a and mul_b  out  OP_W each  operands driven to the pipelined multiplier.
REQ-012 SHALL have port mul_p  in  2*OP_W  product returned by the multiplier.
REQ-013 SHALL have port out_valid  out  1  result available.
REQ-014 SHALL have port out_ready  in  1  consumer accepts the result.
REQ-015 SHALL have port out_p  out  2*OP_W  product.
REQ-016 SHALL have port out_tag  out  TAG_W  tag of that product.
REQ-017 SHALL have port busy  out  1  high while any operation is in flight or the FIFO is non-empty.

Function
REQ-018 SHALL accept an operation on a rising edge where in_valid and in_ready are both high.
REQ-019 SHALL register mul_a/mul_b: on an accepting edge they load in_a/in_b; on any other edge they load zero.
REQ-020 SHALL track in-flight operations with a valid shift register and a parallel tag shift register, each MUL_LAT+1 entries; entry 0 loads "accept" and in_tag.
REQ-021 SHALL push {mul_p, tail tag} into the FIFO on every edge where the tail valid bit is set; mul_p is ignored on all other edges.
REQ-022 SHALL keep inflight = number of set valid bits; occupancy = fifo_count + inflight.
REQ-023 SHALL drive in_ready = (occupancy < DEPTH) from registered state only; in_ready shall not depend on in_valid or out_ready.
REQ-024 SHALL make space freed by a FIFO pop visible on in_ready only from the following cycle, never combinationally.
REQ-025 SHALL assert out_valid MUL_LAT+1 edges after the accepting edge when the FIFO is empty; there is no bypass path.
REQ-026 SHALL pop the FIFO on edges where out_valid and out_ready are both high.
REQ-027 SHALL hold out_p/out_tag stable while out_valid=1 and out_ready=0.
REQ-028 SHALL handle a push and a pop on the same edge with count unchanged, including when the FIFO is full.
REQ-029 SHALL deliver results in acceptance order, with sustained throughput of one per cycle when out_ready=1.
REQ-030 SHALL wrap the FIFO pointers modulo DEPTH; overflow is impossible by construction, so a push while full is an assertion failure.

Reset
REQ-031 SHALL, on an edge with rst=0, clear the valid shift register, FIFO pointers and count, mul_a, mul_b and the tag register; pending results are discarded.
REQ-032 SHALL force out_valid=0, in_ready=0 and busy=0 while rst=0; in_ready=1 in the first cycle after release.
REQ-033 SHALL produce no out_valid for an operation accepted before a mid-operation reset, regardless of what mul_p does afterwards.

Structure
REQ-034 SHALL place OP_W/TAG_W defaults, the MUL_LAT constant and the DEPTH >= MUL_LAT+1 check in the shared multiplier package.
REQ-035 SHALL implement the result buffer as one sub-module, mult_result_fifo: synchronous, registered output, with count.

Verification (bench models the multiplier as a MUL_LAT-stage registered product)
REQ-036 SHALL cover: a=3, b=5, tag=1, out_ready=1 -> out_p=15, tag 1, out_valid exactly 5 edges after accept, busy low afterwards.
REQ-037 SHALL cover: a=0xFFFF, b=0xFFFF -> out_p=0xFFFE0001; a=0, b=0x1234 -> 0.
REQ-038 SHALL cover: 20 back-to-back random pairs with out_ready=1 -> 20 correct results in order on consecutive cycles; in_ready never drops.
REQ-039 SHALL cover: out_ready=0, in_valid held for 12 -> exactly 8 accepted, then in_ready=0; raise out_ready -> 8 results in order, and in_ready returns the cycle after the first pop.
REQ-040 SHALL cover: 3 accepted, then rst=0 for 1 cycle on the second edge after the last accept -> no out_valid ever, occupancy 0, in_ready=1 after release.
REQ-041 SHALL cover: FIFO full, then pop and tail push on the same edge -> count stays 8, with no loss or duplication.
